// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter.
// Command word in (config_reg), status word out (status_reg), serial line out (tx).
// Optional build macro PARITY_EN adds an even-parity bit between the data and stop bits.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] config_reg,
    output logic [31:0] status_reg,
    output logic        tx
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
`else
    localparam logic PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic [7:0]       data_q;
    logic [7:0]       last_byte;
    logic [7:0]       frame_cnt;
    logic             go_q;
    logic             busy;
    logic             overrun;
    logic             done;

    logic go_edge;
    logic bit_end;
    logic unused_cfg;

    assign go_edge    = config_reg[8] & ~go_q;
    assign bit_end    = (bit_cnt == CNT_LAST);
    assign unused_cfg = ^config_reg[31:10];

    // Status word is pure wiring of registers; nothing from config_reg reaches it combinationally.
    assign status_reg = {8'h00, frame_cnt, last_byte, 4'h0, PARITY_FLAG, done, overrun, busy};

    // Frame sequencer, GO edge detection and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            data_q    <= 8'h00;
            last_byte <= 8'h00;
            frame_cnt <= 8'h00;
            go_q      <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            done      <= 1'b0;
            tx        <= 1'b1;
        end else begin
            go_q <= config_reg[8];

            // CLR first so that any set below in the same cycle wins.
            if (config_reg[9]) begin
                overrun <= 1'b0;
                done    <= 1'b0;
            end

            // A command arriving while a frame is in flight is dropped and flagged.
            if (go_edge && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (go_edge) begin
                        shift   <= config_reg[7:0];
                        data_q  <= config_reg[7:0];
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        idx     <= 3'd0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        if (idx == 3'd7) begin
`ifdef PARITY_EN
                            tx    <= ^data_q;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                            tx  <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        bit_cnt   <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        last_byte <= data_q;
                        frame_cnt <= frame_cnt + 8'd1;
                        state     <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx with CLKS_PER_BIT=4; honours PARITY_EN if defined.
module tb_mmio_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef PARITY_EN
    localparam int unsigned NBITS = 11;
    localparam logic [31:0] PF    = 32'h0000_0008;
`else
    localparam int unsigned NBITS = 10;
    localparam logic [31:0] PF    = 32'h0000_0000;
`endif
    localparam int unsigned FRAME = NBITS * CPB;

    logic        clk;
    logic        reset;
    logic [31:0] config_reg;
    logic [31:0] status_reg;
    logic        tx;

    int checks;
    int failures;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .config_reg (config_reg),
        .status_reg (status_reg),
        .tx         (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for a given bit slot of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (slot == 9 && NBITS == 11) return ^b;
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        config_reg = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (tx !== 1'b1 || status_reg !== PF) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d tx=%b status=%h expected tx=1 status=%h", k, tx, status_reg, PF);
            end
            tick();
        end
    endtask

    task automatic test_frame();
        config_reg = 32'h0000_0155;
        tick();
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (tx !== exp_bit(8'h55, k / CPB) || status_reg[0] !== 1'b1) begin
                failures++;
                $display("FAIL frame55 cycle=%0d tx=%b busy=%b expected tx=%b busy=1", k, tx, status_reg[0], exp_bit(8'h55, k / CPB));
            end
            tick();
        end
        checks++;
        if (status_reg !== (32'h0001_5504 | PF)) begin
            failures++;
            $display("FAIL frame55_status got=%h expected=%h", status_reg, 32'h0001_5504 | PF);
        end
        // GO still held high: no second frame.
        tick();
        tick();
        checks++;
        if (tx !== 1'b1 || status_reg[0] !== 1'b0) begin
            failures++;
            $display("FAIL go_held tx=%b busy=%b expected tx=1 busy=0", tx, status_reg[0]);
        end
    endtask

    task automatic test_overrun();
        config_reg = 32'h0;
        tick();
        config_reg = 32'h0000_013C;
        tick();
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (tx !== exp_bit(8'h3C, k / CPB)) begin
                failures++;
                $display("FAIL overrun_frame cycle=%0d tx=%b expected=%b", k, tx, exp_bit(8'h3C, k / CPB));
            end
            if (k == 5) config_reg = 32'h0000_003C;
            if (k == 12) config_reg = 32'h0000_01A3;
            if (k == 14) begin
                checks++;
                if (status_reg[1:0] !== 2'b11) begin
                    failures++;
                    $display("FAIL overrun_flag got=%b expected=11", status_reg[1:0]);
                end
            end
            tick();
        end
        checks++;
        if (status_reg !== (32'h0002_3C06 | PF)) begin
            failures++;
            $display("FAIL overrun_status got=%h expected=%h", status_reg, 32'h0002_3C06 | PF);
        end
    endtask

    // GO edge coincides with STOP completion, and CLR high on that same edge.
    task automatic test_stop_edge();
        config_reg = 32'h0;
        tick();
        config_reg = 32'h0000_0181;
        tick();
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (tx !== exp_bit(8'h81, k / CPB)) begin
                failures++;
                $display("FAIL stop_edge_frame cycle=%0d tx=%b expected=%b", k, tx, exp_bit(8'h81, k / CPB));
            end
            if (k == 20) config_reg = 32'h0000_0081;
            if (k == FRAME - 1) config_reg = 32'h0000_0381;
            tick();
        end
        config_reg = 32'h0000_0181;
        checks++;
        if (status_reg !== (32'h0003_8106 | PF)) begin
            failures++;
            $display("FAIL stop_edge_status got=%h expected=%h", status_reg, 32'h0003_8106 | PF);
        end
        tick();
        tick();
        checks++;
        if (tx !== 1'b1 || status_reg[0] !== 1'b0) begin
            failures++;
            $display("FAIL stop_edge_no_start tx=%b busy=%b expected tx=1 busy=0", tx, status_reg[0]);
        end
    endtask

    task automatic test_clear();
        config_reg = 32'h0000_0200;
        tick();
        checks++;
        if (status_reg !== (32'h0003_8100 | PF)) begin
            failures++;
            $display("FAIL clear got=%h expected=%h", status_reg, 32'h0003_8100 | PF);
        end
        config_reg = 32'h0;
        tick();
        checks++;
        if (status_reg !== (32'h0003_8100 | PF)) begin
            failures++;
            $display("FAIL clear_hold got=%h expected=%h", status_reg, 32'h0003_8100 | PF);
        end
    endtask

    task automatic test_reset_mid_frame();
        config_reg = 32'h0000_01C3;
        tick();
        for (int k = 0; k < 16; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (tx !== 1'b1 || status_reg !== PF) begin
            failures++;
            $display("FAIL reset_mid tx=%b status=%h expected tx=1 status=%h", tx, status_reg, PF);
        end
        // GO still high after reset counts as a fresh edge.
        tick();
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (tx !== exp_bit(8'hC3, k / CPB) || status_reg[0] !== 1'b1) begin
                failures++;
                $display("FAIL post_reset_frame cycle=%0d tx=%b busy=%b expected tx=%b busy=1", k, tx, status_reg[0], exp_bit(8'hC3, k / CPB));
            end
            tick();
        end
        checks++;
        if (status_reg !== (32'h0001_C304 | PF)) begin
            failures++;
            $display("FAIL post_reset_status got=%h expected=%h", status_reg, 32'h0001_C304 | PF);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic [7:0] cnt;
        int n;
        reset = 1'b1;
        config_reg = 32'h0;
        tick();
        reset = 1'b0;
        cnt = 8'h00;
        b = 8'h00;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i) ^ 8'h5A;
            config_reg = {23'h0, 1'b1, b};
            tick();
            n = 0;
            while (status_reg[0] === 1'b1 && n < 200) begin
                tick();
                n++;
            end
            cnt = cnt + 8'd1;
            checks++;
            if (n !== FRAME || status_reg[23:8] !== {cnt, b}) begin
                failures++;
                $display("FAIL b2b frame=%0d len=%0d cnt_byte=%h expected len=%0d cnt_byte=%h", i, n, status_reg[23:8], FRAME, {cnt, b});
            end
            config_reg = {23'h0, 1'b0, b};
            tick();
        end
        checks++;
        if (status_reg[23:16] !== 8'h00 || status_reg[15:8] !== 8'hA5) begin
            failures++;
            $display("FAIL b2b_wrap cnt=%h byte=%h expected cnt=00 byte=a5", status_reg[23:16], status_reg[15:8]);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        config_reg = 32'h0;
        test_reset();
        test_frame();
        test_overrun();
        test_stop_edge();
        test_clear();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
